// File: rtl/serv_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// serv_dbg_ctrl
//
// Debug-side controller for the SERV decoder's halt/step inputs. A host issues
// HALT / RESUME / STEP / NOP commands over a valid/ready request port and gets
// exactly one response pulse per accepted command. The controller watches the
// decoder's dbg_process flag to see the core enter debug mode (ebreak taken)
// and leave it again (dret), and reports the last halt cause using the dcsr
// cause encoding (1 ebreak, 3 haltreq, 4 step).
//
// Optional feature macro: DBG_TIMEOUT_EN
//   defined   : a HALT that sees no entry into debug mode within HALT_TIMEOUT
//               cycles is abandoned and answered with an error response.
//   undefined : HALTING waits indefinitely for the core to enter debug mode.
//
// Parameters
//   HALT_TIMEOUT  cycles allowed in HALTING (DBG_TIMEOUT_EN only)
//   CW            timeout counter width, 2**CW > HALT_TIMEOUT
//
// Ports
//   clk            core clock
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    host command valid
//   i_req_cmd      00 NOP, 01 HALT, 10 RESUME, 11 STEP
//   o_req_ready    command accepted when valid & ready (RUN / HALTED only)
//   o_rsp_valid    one-cycle response pulse per accepted command
//   o_rsp_err      qualifies o_rsp_valid: command rejected or timed out
//   o_dbg_halt     to decoder i_dbg_halt
//   o_dbg_step     to decoder i_dbg_step
//   i_dbg_process  from decoder o_dbg_process (core is in debug mode)
//   o_resume_req   level request polled by the debug handler to execute dret
//   o_halted       high while halted
//   o_halt_evt     one-cycle pulse on every entry to the halted state
//   o_cause        last halt cause
// ---------------------------------------------------------------------------
module serv_dbg_ctrl #(
  parameter int unsigned HALT_TIMEOUT = 1024,
  parameter int unsigned CW           = 11
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_cmd,
  output logic       o_req_ready,
  output logic       o_rsp_valid,
  output logic       o_rsp_err,
  output logic       o_dbg_halt,
  output logic       o_dbg_step,
  input  logic       i_dbg_process,
  output logic       o_resume_req,
  output logic       o_halted,
  output logic       o_halt_evt,
  output logic [2:0] o_cause
);

  // The timeout counter must be able to reach HALT_TIMEOUT-1.
  if ((2 ** CW) <= HALT_TIMEOUT) begin : g_cw_check
    $error("serv_dbg_ctrl: CW too narrow for HALT_TIMEOUT");
  end

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED,
    ST_RESUMING,
    ST_STEPPING
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_HALT   = 2'b01,
    CMD_RESUME = 2'b10,
    CMD_STEP   = 2'b11
  } cmd_t;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  state_t     r_state;
  logic       r_proc_q;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic       r_rsp_err;
  logic       r_dbg_halt;
  logic       r_dbg_step;
  logic       r_resume_req;
  logic       r_halted;
  logic       r_halt_evt;
  logic [2:0] r_cause;

  cmd_t       w_cmd;
  logic       w_accept;
  logic       w_proc_rise;
  logic       w_proc_fall;

  assign w_cmd       = cmd_t'(i_req_cmd);
  assign w_accept    = i_req_valid & r_req_ready;
  // Debug-mode entry/exit are judged against the previous cycle's flag.
  assign w_proc_rise = i_dbg_process & ~r_proc_q;
  assign w_proc_fall = ~i_dbg_process & r_proc_q;

`ifdef DBG_TIMEOUT_EN
  logic [CW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  // The counter reads k-1 in the k-th cycle spent in HALTING, so this fires
  // at the end of cycle HALT_TIMEOUT.
  assign w_tmo_hit = (r_tmo_cnt == CW'(HALT_TIMEOUT - 1));
`endif

  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values; the pulse outputs get a default of 0 at the top of the
  // clocked branch and the later assignment in the case body wins.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_proc_q     <= 1'b0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_dbg_halt   <= 1'b0;
      r_dbg_step   <= 1'b0;
      r_resume_req <= 1'b0;
      r_halted     <= 1'b0;
      r_halt_evt   <= 1'b0;
      r_cause      <= 3'd0;
`ifdef DBG_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_proc_q    <= i_dbg_process;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_halt_evt  <= 1'b0;

      case (r_state)
        ST_RUN: begin
          r_req_ready <= 1'b1;
          if (w_proc_rise) begin
            // Software ebreak, or an ebreak racing an accepted command:
            // the ebreak defines the halt cause either way.
            r_state    <= ST_HALTED;
            r_halted   <= 1'b1;
            r_cause    <= CAUSE_EBREAK;
            r_halt_evt <= 1'b1;
            if (w_accept) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= (w_cmd == CMD_RESUME) || (w_cmd == CMD_STEP);
            end
          end else if (w_accept) begin
            case (w_cmd)
              CMD_HALT: begin
                r_state     <= ST_HALTING;
                r_dbg_halt  <= 1'b1;
                r_req_ready <= 1'b0;
`ifdef DBG_TIMEOUT_EN
                r_tmo_cnt   <= '0;
`endif
              end
              CMD_NOP: begin
                r_rsp_valid <= 1'b1;
              end
              default: begin
                // RESUME / STEP make no sense while running.
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        ST_HALTING: begin
          // Halt request is held until the core is seen in debug mode; the
          // decoder may need several cycles to inject the ebreak.
          if (w_proc_rise) begin
            r_state     <= ST_HALTED;
            r_dbg_halt  <= 1'b0;
            r_halted    <= 1'b1;
            r_req_ready <= 1'b1;
            r_cause     <= CAUSE_HALTREQ;
            r_halt_evt  <= 1'b1;
            r_rsp_valid <= 1'b1;
          end
`ifdef DBG_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_state     <= ST_RUN;
            r_dbg_halt  <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
`endif
        end

        ST_HALTED: begin
          if (w_accept) begin
            case (w_cmd)
              CMD_RESUME: begin
                r_state      <= ST_RESUMING;
                r_resume_req <= 1'b1;
                r_halted     <= 1'b0;
                r_req_ready  <= 1'b0;
              end
              CMD_STEP: begin
                r_state      <= ST_STEPPING;
                r_resume_req <= 1'b1;
                r_dbg_step   <= 1'b1;
                r_halted     <= 1'b0;
                r_req_ready  <= 1'b0;
              end
              default: begin
                // NOP, or HALT while already halted.
                r_rsp_valid <= 1'b1;
              end
            endcase
          end
        end

        ST_RESUMING: begin
          if (w_proc_fall) begin
            r_state      <= ST_RUN;
            r_resume_req <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b1;
          end
        end

        ST_STEPPING: begin
          // Step stays asserted across the dret so the decoder re-enters
          // debug after exactly one instruction.
          if (w_proc_fall) begin
            r_resume_req <= 1'b0;
          end
          if (w_proc_rise) begin
            r_state     <= ST_HALTED;
            r_dbg_step  <= 1'b0;
            r_halted    <= 1'b1;
            r_req_ready <= 1'b1;
            r_cause     <= CAUSE_STEP;
            r_halt_evt  <= 1'b1;
            r_rsp_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_err    = r_rsp_err;
  assign o_dbg_halt   = r_dbg_halt;
  assign o_dbg_step   = r_dbg_step;
  assign o_resume_req = r_resume_req;
  assign o_halted     = r_halted;
  assign o_halt_evt   = r_halt_evt;
  assign o_cause      = r_cause;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serv_dbg_ctrl
//
// Scoreboard bench for serv_dbg_ctrl. The driver plays both the host and the
// core's dbg_process flag; every accepted command pushes its expected
// rsp_err into a queue and a monitor pops/compares on each o_rsp_valid.
// A small abstract model (halted?, last cause, number of halt entries) is
// compared against the status outputs whenever the DUT is quiescent.
// ---------------------------------------------------------------------------
module tb_serv_dbg_ctrl;

  localparam int HALT_TIMEOUT = 8;
  localparam int CW           = 4;

  localparam logic [1:0] C_NOP    = 2'b00;
  localparam logic [1:0] C_HALT   = 2'b01;
  localparam logic [1:0] C_RESUME = 2'b10;
  localparam logic [1:0] C_STEP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic       proc = 1'b0;

  logic       o_req_ready, o_rsp_valid, o_rsp_err;
  logic       o_dbg_halt, o_dbg_step, o_resume_req, o_halted, o_halt_evt;
  logic [2:0] o_cause;

  always #5 clk = ~clk;

  serv_dbg_ctrl #(
    .HALT_TIMEOUT (HALT_TIMEOUT),
    .CW           (CW)
  ) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_cmd     (req_cmd),
    .o_req_ready   (o_req_ready),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_err     (o_rsp_err),
    .o_dbg_halt    (o_dbg_halt),
    .o_dbg_step    (o_dbg_step),
    .i_dbg_process (proc),
    .o_resume_req  (o_resume_req),
    .o_halted      (o_halted),
    .o_halt_evt    (o_halt_evt),
    .o_cause       (o_cause)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int n_issued  = 0;
  int n_dropped = 0;
  int n_rsp     = 0;
  int evt_seen  = 0;

  bit exp_q[$];      // expected rsp_err per accepted command, in order

  // Abstract model of the debug controller's visible status.
  bit m_halted = 1'b0;
  int m_cause  = 0;
  int m_evt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts halt-entry pulses and scores every response.
  always @(negedge clk) begin
    bit e;
    if (o_halt_evt === 1'b1) evt_seen++;
    if (o_rsp_valid === 1'b1) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", o_rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", o_rsp_err, e);
      end
    end
  end

  // Present one command; optionally raise dbg_process in the same cycle and
  // optionally check the one-cycle response latency of immediate commands.
  task automatic issue(input logic [1:0] cmd, input bit exp_err,
                       input bit immediate, input bit with_rise);
    int waited = 0;
    @(negedge clk);
    while (o_req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (o_req_ready !== 1'b1) begin
      check("req_ready_wait", o_req_ready, 1);
      return;
    end
    req_valid = 1'b1;
    req_cmd   = cmd;
    if (with_rise) proc = 1'b1;
    exp_q.push_back(exp_err);
    n_issued++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = C_NOP;
    if (immediate) begin
      @(negedge clk);
      check("rsp_latency", o_rsp_valid, 1);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_state();
    check("halted",          o_halted,     m_halted);
    check("cause",           o_cause,      m_cause);
    check("halt_evt_count",  evt_seen,     m_evt);
    check("dbg_halt_idle",   o_dbg_halt,   0);
    check("dbg_step_idle",   o_dbg_step,   0);
    check("resume_req_idle", o_resume_req, 0);
    check("req_ready_idle",  o_req_ready,  1);
  endtask

  task automatic check_all_zero();
    check("rst_req_ready",  o_req_ready,  0);
    check("rst_rsp_valid",  o_rsp_valid,  0);
    check("rst_rsp_err",    o_rsp_err,    0);
    check("rst_dbg_halt",   o_dbg_halt,   0);
    check("rst_dbg_step",   o_dbg_step,   0);
    check("rst_resume_req", o_resume_req, 0);
    check("rst_halted",     o_halted,     0);
    check("rst_halt_evt",   o_halt_evt,   0);
    check("rst_cause",      o_cause,      0);
  endtask

  // HALT from RUN; the core enters debug d cycles after acceptance.
  task automatic do_halt(input int d);
    issue(C_HALT, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check("dbg_halt_held", o_dbg_halt, 1);
      check("ready_busy", o_req_ready, 0);
    end
    proc = 1'b1;
    drain();
    m_halted = 1'b1;
    m_cause  = 3;
    m_evt++;
    check_state();
  endtask

  // RESUME from HALTED; the handler executes dret d cycles later.
  task automatic do_resume(input int d);
    issue(C_RESUME, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check("resume_req_held", o_resume_req, 1);
      check("ready_busy", o_req_ready, 0);
    end
    proc = 1'b0;
    drain();
    m_halted = 1'b0;
    check_state();
  endtask

  // STEP from HALTED: dret after d cycles, re-entry to debug d2 cycles later.
  task automatic do_step(input int d, input int d2);
    issue(C_STEP, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check("step_resume_req", o_resume_req, 1);
      check("step_held", o_dbg_step, 1);
    end
    proc = 1'b0;
    @(negedge clk);
    check("step_resume_dropped", o_resume_req, 0);
    check("step_held_after_fall", o_dbg_step, 1);
    for (int i = 0; i < d2; i++) begin
      @(negedge clk);
      check("step_held_running", o_dbg_step, 1);
      check("step_not_halted", o_halted, 0);
    end
    proc = 1'b1;
    drain();
    m_halted = 1'b1;
    m_cause  = 4;
    m_evt++;
    check_state();
  endtask

  // Software ebreak while running: halt with no response.
  task automatic do_ebreak();
    @(negedge clk);
    proc = 1'b1;
    @(negedge clk);
    check("ebreak_halted", o_halted, 1);
    check("ebreak_no_rsp", o_rsp_valid, 0);
    @(negedge clk);
    m_halted = 1'b1;
    m_cause  = 1;
    m_evt++;
    check_state();
  endtask

  // HALT accepted in the same cycle the core takes an ebreak: ebreak wins.
  task automatic do_tie();
    issue(C_HALT, 1'b0, 1'b1, 1'b1);
    check("tie_no_dbg_halt", o_dbg_halt, 0);
    check("tie_halted", o_halted, 1);
    @(negedge clk);
    m_halted = 1'b1;
    m_cause  = 1;
    m_evt++;
    check_state();
  endtask

  task automatic do_reset_mid_step();
    issue(C_STEP, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    proc = 1'b0;
    repeat (2) @(negedge clk);
    check("step_before_reset", o_dbg_step, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero();
    n_dropped += exp_q.size();
    exp_q.delete();
    m_halted = 1'b0;
    m_cause  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", o_req_ready, 1);

    do_halt(5);
    do_resume(20);
    do_halt(1);
    do_step(3, 2);
    do_resume(4);
    do_ebreak();
    issue(C_HALT, 1'b0, 1'b1, 1'b0);
    check("halt_while_halted", o_halted, 1);
    do_resume(2);
    issue(C_RESUME, 1'b1, 1'b1, 1'b0);
    issue(C_STEP, 1'b1, 1'b1, 1'b0);
    issue(C_NOP, 1'b0, 1'b1, 1'b0);
    check("still_running", o_halted, 0);
    do_tie();
    do_reset_mid_step();

    for (int it = 0; it < 40; it++) begin
      if (!m_halted) begin
        case ($urandom_range(0, 4))
          0: do_halt($urandom_range(1, 8));
          1: do_ebreak();
          2: issue(C_NOP, 1'b0, 1'b1, 1'b0);
          3: issue(($urandom_range(0, 1) != 0) ? C_RESUME : C_STEP, 1'b1, 1'b1, 1'b0);
          default: do_tie();
        endcase
      end else begin
        case ($urandom_range(0, 3))
          0: issue(($urandom_range(0, 1) != 0) ? C_HALT : C_NOP, 1'b0, 1'b1, 1'b0);
          1: do_resume($urandom_range(1, 20));
          default: do_step($urandom_range(1, 6), $urandom_range(1, 4));
        endcase
      end
      check("model_halted", o_halted, m_halted);
    end

`ifdef DBG_TIMEOUT_EN
    if (m_halted) do_resume(3);
    begin
      int cnt = 0;
      issue(C_HALT, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (o_dbg_halt === 1'b1) cnt++;
        else break;
      end
      check("timeout_cycles", cnt, HALT_TIMEOUT);
      drain();
      check_state();
    end
`endif

    repeat (3) @(negedge clk);
    check("rsp_count", n_rsp, n_issued - n_dropped);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog run did not complete by t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
